mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared FSM state type, access-size encodings and lane helpers for the data memory access unit.
package mem_pkg;

   localparam int unsigned MAX_WAIT_DEFAULT = 15;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } mem_state_e;

   // Address bits below the access size are forced to zero.
   function automatic logic [1:0] eff_lo(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         MEM_SIZE_BYTE: eff_lo = lo;
         MEM_SIZE_HALF: eff_lo = {lo[1], 1'b0};
         default:       eff_lo = 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         MEM_SIZE_BYTE: byte_en = 4'b0001 << lo;
         MEM_SIZE_HALF: byte_en = 4'b0011 << lo;
         default:       byte_en = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
      case (size)
         MEM_SIZE_BYTE: store_lanes = {4{data[7:0]}};
         MEM_SIZE_HALF: store_lanes = {2{data[15:0]}};
         default:       store_lanes = data;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed lane of a read word and sign- or zero-extends it to 32 bits.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'b00: byte_lane = rdata[7:0];
         2'b01: byte_lane = rdata[15:8];
         2'b10: byte_lane = rdata[23:16];
         2'b11: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (size)
         MEM_SIZE_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         MEM_SIZE_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
         default:       data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: registers load/store requests onto the dmem bus and stalls the pipeline.
// Build option MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses and adds the MisalignM pulse.
//
// state   | meaning
// ST_IDLE | no access in flight; a MEM-stage load/store is issued on the next edge
// ST_WAIT | request on the bus, waiting for dmem_ack or the wait timer to expire
// ST_DONE | one cycle with StallM low so the instruction advances
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [1:0]  MemSizeM,
   input  logic        MemSignedM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] RD,
   output logic        StallM,
   output logic        BusErrM,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        MisalignM,
`endif
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

   mem_state_e       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             op_req;
   logic             misalign;
   logic [1:0]       lo_eff;
   logic             ld_pend;
   logic [1:0]       ld_lo;
   logic [1:0]       ld_size;
   logic             ld_signed;
   logic [31:0]      ld_data;

   assign op_req = MemReadM | MemWriteM;
   assign lo_eff = eff_lo(MemSizeM, ALUOutM[1:0]);
   assign StallM = ((state == ST_IDLE) && op_req) || (state == ST_WAIT);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = ((MemSizeM == MEM_SIZE_HALF) && ALUOutM[0]) ||
                     (MemSizeM[1] && (ALUOutM[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   mem_load_align u_load_align (
      .rdata    (dmem_rdata),
      .addr_lo  (ld_lo),
      .size     (ld_size),
      .sign_ext (ld_signed),
      .data     (ld_data)
   );

   // Timer loads MAX_WAIT-1 on issue and counts down; terminal count at zero aborts the access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         RD         <= '0;
         BusErrM    <= 1'b0;
         ld_pend    <= 1'b0;
         ld_lo      <= '0;
         ld_size    <= '0;
         ld_signed  <= 1'b0;
      end else begin
         BusErrM <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (op_req) begin
                  if (misalign) begin
                     state <= ST_DONE;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= MemWriteM;
                     dmem_addr  <= {ALUOutM[31:2], 2'b00};
                     dmem_be    <= byte_en(MemSizeM, lo_eff);
                     dmem_wdata <= store_lanes(MemSizeM, WriteDataM);
                     ld_pend    <= ~MemWriteM;
                     ld_lo      <= lo_eff;
                     ld_size    <= MemSizeM;
                     ld_signed  <= MemSignedM;
                     wait_cnt   <= CNT_W'(MAX_WAIT - 1);
                     state      <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (ld_pend) RD <= ld_data;
                  state    <= ST_DONE;
               end else if (wait_cnt == '0) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  BusErrM  <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               wait_cnt <= '0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) MisalignM <= 1'b0;
      else        MisalignM <= (state == ST_IDLE) && op_req && misalign;
   end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-addressed memory reference model.
module tb_mem_access_unit;

   localparam int MAX_WAIT = 15;
   localparam int MEM_BYTES = 1024;

   logic        clk;
   logic        rst_n;
   logic        MemReadM, MemWriteM, MemSignedM;
   logic [1:0]  MemSizeM;
   logic [31:0] ALUOutM, WriteDataM;
   logic [31:0] RD;
   logic        StallM, BusErrM;
`ifdef MEM_ALIGN_CHECK_EN
   logic        MisalignM;
`endif
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_rd;
   logic [7:0]  mem_b [0:MEM_BYTES-1];

   mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .MemSizeM   (MemSizeM),
      .MemSignedM (MemSignedM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .RD         (RD),
      .StallM     (StallM),
      .BusErrM    (BusErrM),
`ifdef MEM_ALIGN_CHECK_EN
      .MisalignM  (MisalignM),
`endif
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_be    (dmem_be),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] load_model(input int unsigned a, input int nb, input bit sgn);
      longint v;
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(mem_b[a + i]) << (8 * i));
      if (sgn && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
      return v[31:0];
   endfunction

   function automatic logic [31:0] word_at(input int unsigned w);
      return {mem_b[w + 3], mem_b[w + 2], mem_b[w + 1], mem_b[w]};
   endfunction

   // ack_at: WAIT cycle (1-based) on which dmem_ack is given; 0 means never (timeout).
   task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                            input int unsigned addr, input logic [31:0] wd, input int ack_at);
      int          nb;
      int unsigned eff;
      int unsigned wbase;
      int          stalls;
      logic [31:0] exp_be, exp_wd;
      nb     = nbytes(sz);
      eff    = (addr / nb) * nb;
      wbase  = (eff / 4) * 4;
      exp_be = ((32'd1 << nb) - 1) << (eff % 4);
      exp_wd = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
               (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      stalls = 0;

      @(negedge clk);
      MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sgn;
      ALUOutM = addr; WriteDataM = wd; dmem_ack = 1'b0;
      #1;
      stalls += int'(StallM);

`ifdef MEM_ALIGN_CHECK_EN
      if (nb > 1 && (addr % nb) != 0) begin
         @(negedge clk); #1;
         stalls += int'(StallM);
         chk("mis_pulse", 32'(MisalignM), 1);
         chk("mis_noreq", 32'(dmem_req), 0);
         chk("mis_rd", RD, exp_rd);
         chk("mis_stall_cnt", stalls, 1);
         @(negedge clk);
         MemReadM = 1'b0; MemWriteM = 1'b0;
         #1;
         chk("mis_clear", 32'(MisalignM), 0);
         return;
      end
`endif

      for (int c = 1; c <= MAX_WAIT; c++) begin
         @(negedge clk); #1;
         stalls += int'(StallM);
         chk("req_wait", 32'(dmem_req), 1);
         if (c == 1) begin
            chk("addr", dmem_addr, wbase);
            chk("be", 32'(dmem_be), exp_be);
            chk("we", 32'(dmem_we), 32'(wr));
            if (wr) chk("wdata", dmem_wdata, exp_wd);
         end
         if (c == ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = wr ? $urandom : word_at(wbase);
            break;
         end
      end

      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      stalls += int'(StallM);
      if (ack_at != 0) begin
         if (wr) begin
            for (int i = 0; i < nb; i++) mem_b[eff + i] = 8'(wd >> (8 * i));
         end else begin
            exp_rd = load_model(eff, nb, sgn);
         end
      end
      chk("done_req", 32'(dmem_req), 0);
      chk("done_buserr", 32'(BusErrM), (ack_at == 0) ? 1 : 0);
      chk("done_rd", RD, exp_rd);
      chk("stall_cnt", stalls, (ack_at == 0) ? 1 + MAX_WAIT : 1 + ack_at);

      // Return to IDLE; a stray ack here must have no effect.
      @(negedge clk);
      MemReadM = 1'b0; MemWriteM = 1'b0;
      dmem_ack = (ack_at == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(StallM), 0);
      chk("idle_buserr", 32'(BusErrM), 0);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      chk("idle_req", 32'(dmem_req), 0);
      chk("idle_rd", RD, exp_rd);
   endtask

   initial begin
      logic        r_rd, r_wr, r_sgn;
      logic [1:0]  r_sz;
      int unsigned r_addr;
      int          r_ack;

      n_tests = 0; n_fail = 0; exp_rd = '0;
      for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'($urandom);
      rst_n = 1'b0;
      MemReadM = 0; MemWriteM = 0; MemSizeM = 0; MemSignedM = 0;
      ALUOutM = 0; WriteDataM = 0; dmem_rdata = 0; dmem_ack = 0;
      #3;
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_we", 32'(dmem_we), 0);
      chk("rst_be", 32'(dmem_be), 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_rd", RD, 0);
      chk("rst_buserr", 32'(BusErrM), 0);
      chk("rst_stall", 32'(StallM), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // lw at 0x100, ack on 2nd WAIT cycle
      mem_b[32'h100] = 8'hEF; mem_b[32'h101] = 8'hBE; mem_b[32'h102] = 8'hAD; mem_b[32'h103] = 8'hDE;
      do_access(1, 0, 2'b10, 0, 32'h100, 0, 2);
      chk("lw_rd", RD, 32'hDEADBEEF);

      // lb / lbu at 0x103
      mem_b[32'h100] = 8'h33; mem_b[32'h101] = 8'h22; mem_b[32'h102] = 8'h11; mem_b[32'h103] = 8'h80;
      do_access(1, 0, 2'b00, 1, 32'h103, 0, 1);
      chk("lb_rd", RD, 32'hFFFFFF80);
      do_access(1, 0, 2'b00, 0, 32'h103, 0, 1);
      chk("lbu_rd", RD, 32'h00000080);

      // sh 0xABCD at 0x102, then read it back as a signed half
      do_access(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 1);
      do_access(1, 0, 2'b01, 1, 32'h102, 0, 3);
      chk("lh_rd", RD, 32'hFFFFABCD);

      // timeout with late ack; RD keeps the previous load
      do_access(1, 0, 2'b10, 0, 32'h200, 0, 0);
      chk("tmo_rd", RD, 32'hFFFFABCD);

      // reset asserted during WAIT
      @(negedge clk);
      MemReadM = 1; MemSizeM = 2'b10; ALUOutM = 32'h40;
      @(negedge clk); #1;
      chk("pre_rst_req", 32'(dmem_req), 1);
      @(negedge clk);
      rst_n = 1'b0; MemReadM = 0;
      #1;
      exp_rd = '0;
      chk("rst_mid_req", 32'(dmem_req), 0);
      chk("rst_mid_rd", RD, 0);
      chk("rst_mid_stall", 32'(StallM), 0);
      @(negedge clk);
      rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
      #1;
      chk("rst_late_stall", 32'(StallM), 0);
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      chk("rst_late_req", 32'(dmem_req), 0);
      chk("rst_late_rd", RD, 0);

`ifdef MEM_ALIGN_CHECK_EN
      do_access(1, 0, 2'b10, 0, 32'h102, 0, 1);
`endif

      for (int n = 0; n < 40; n++) begin
         r_rd   = 1'($urandom_range(0, 1));
         r_wr   = r_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
         r_sz   = 2'($urandom_range(0, 3));
         r_sgn  = 1'($urandom_range(0, 1));
         r_addr = $urandom_range(0, MEM_BYTES - 1);
         r_ack  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
         do_access(r_rd, r_wr, r_sz, r_sgn, r_addr, $urandom, r_ack);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
